// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, branch/jump redirect and interrupt-entry controller.
// Priority per cycle: taken branch, load-use bubble, interrupt take, jump.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRt,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_Rt,
  input  logic        ID_Jump,
  input  logic        EX_BrTaken,
  input  logic        ID_Eret,
  input  logic        irq,
  output logic        PC_Stall,
  output logic        IFID_Stall,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic [1:0]  PC_Sel,
  output logic        EPC_Wr,
  output logic        IRQ_Ack,
  output logic        InKernel,
  output logic [15:0] StallCnt
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] TAKE = 2'd2;
  localparam logic [1:0] KERN = 2'd3;

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_VEC  = 2'b11;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       rs_hit;
  logic       rt_hit;
  logic       load_use;
  logic       act_br;
  logic       act_lu;
  logic       act_take;
  logic       act_jump;
  logic       pend_clean;

  assign rs_hit   = (EX_Rt == ID_Rs);
  assign rt_hit   = ID_UseRt && (EX_Rt == ID_Rt);
  assign load_use = EX_MemRd && (EX_Rt != 5'd0) && (rs_hit || rt_hit);

  assign act_br   = EX_BrTaken;
  assign act_lu   = load_use && !EX_BrTaken;
  // A branch or bubble landing in the TAKE cycle wins; the take waits in TAKE.
  assign act_take = (state == TAKE) && !EX_BrTaken && !load_use;
  assign act_jump = ID_Jump && !EX_BrTaken && !load_use && !act_take;

  assign pend_clean = !EX_BrTaken && !load_use && !ID_Jump;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (irq) state_nxt = PEND;
      PEND: begin
        if (!irq)           state_nxt = RUN;
        else if (pend_clean) state_nxt = TAKE;
      end
      TAKE: if (act_take) state_nxt = KERN;
      KERN: if (ID_Eret) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= 16'd0;
    end else if (act_lu && (StallCnt != 16'hFFFF)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end

  assign InKernel = (state == KERN);

  // Held at zero while reset is low, whatever the pipeline inputs show.
  always_comb begin
    PC_Stall   = 1'b0;
    IFID_Stall = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    PC_Sel     = SEL_PC4;
    EPC_Wr     = 1'b0;
    IRQ_Ack    = 1'b0;
    if (reset) begin
      if (act_br) begin
        PC_Sel     = SEL_BR;
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (act_lu) begin
        PC_Stall   = 1'b1;
        IFID_Stall = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (act_take) begin
        PC_Sel     = SEL_VEC;
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
        EPC_Wr     = 1'b1;
        IRQ_Ack    = 1'b1;
      end else if (act_jump) begin
        PC_Sel     = SEL_JUMP;
        IFID_Flush = 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide reset  input  1  asynchronous, active-low; all state clears on negedge reset, independent of clk.
REQ-003 SHALL provide ID_Rs, ID_Rt  input  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL provide ID_UseRt  input  1  ID instruction reads Rt (R-type, beq, sw).
REQ-005 SHALL provide EX_MemRd, EX_Rt  input  1, 5  EX instruction is a load; its destination register.
REQ-006 SHALL provide ID_Jump  input  1  j/jal/jr decoded in ID; target valid this cycle.
REQ-007 SHALL provide EX_BrTaken  input  1  branch in EX resolved taken.
REQ-008 SHALL provide ID_Eret  input  1  return-from-interrupt decoded in ID.
REQ-009 SHALL provide irq  input  1  level-sensitive external interrupt request.
REQ-010 SHALL provide PC_Stall, IFID_Stall  output  1 each  hold PC / IF_ID register.
REQ-011 SHALL provide IFID_Flush, IDEX_Flush  output  1 each  load zeros (bubble) into IF_ID / ID_EX.
REQ-012 SHALL provide PC_Sel  output  2  00 PC+4, 01 jump target, 10 branch target, 11 interrupt vector.
REQ-013 SHALL provide EPC_Wr, IRQ_Ack  output  1 each  capture ID-stage PC into EPC; one-cycle acknowledge to interrupt source.
REQ-014 SHALL provide InKernel  output  1  interrupt handler active (irq masked).
REQ-015 SHALL provide StallCnt  output  16  saturating count of load-use stall cycles.

Function
REQ-016 SHALL detect load-use: LU = EX_MemRd & EX_Rt!=0 & (EX_Rt==ID_Rs | (ID_UseRt & EX_Rt==ID_Rt)).
REQ-017 SHALL apply event priority, highest first: EX_BrTaken, LU, interrupt take, ID_Jump; one action per cycle.
REQ-018 EX_BrTaken: PC_Sel=10, IFID_Flush=1, IDEX_Flush=1; LU and ID_Jump ignored that cycle.
REQ-019 LU (no branch): PC_Stall=1, IFID_Stall=1, IDEX_Flush=1, PC_Sel=00; exactly one bubble per hazard.
REQ-020 ID_Jump (no higher event): PC_Sel=01, IFID_Flush=1; ID_EX loads normally.
REQ-021 Stall and flush SHALL never both assert on IF_ID in one cycle; Flush wins only under EX_BrTaken.
REQ-022 SHALL implement FSM RUN, PEND, TAKE, KERN.
REQ-023 RUN -> PEND when irq=1 and InKernel=0.
REQ-024 PEND -> TAKE on first cycle with EX_BrTaken=0, LU=0, ID_Jump=0; otherwise remain PEND (no control-flow loss).
REQ-025 PEND -> RUN if irq deasserts before take; no acknowledge issued.
REQ-026 TAKE (one cycle): PC_Sel=11, IFID_Flush=1, IDEX_Flush=1, EPC_Wr=1, IRQ_Ack=1; next state KERN.
REQ-027 KERN: InKernel=1, irq ignored; ID_Eret=1 -> RUN next cycle; hazard logic REQ-016..021 active in all states.
REQ-028 ID_Eret in RUN/PEND SHALL be ignored by the FSM.
REQ-029 StallCnt SHALL increment each LU cycle, saturate at 16'hFFFF, never wrap.
REQ-030 Outputs other than StallCnt/InKernel SHALL be combinational from inputs and state, same-cycle.

Reset
REQ-031 While reset=0: state RUN, InKernel=0, StallCnt=0, all stall/flush/EPC_Wr/IRQ_Ack=0, PC_Sel=00.
REQ-032 Reset asserted mid-PEND or mid-KERN SHALL abandon the interrupt; no IRQ_Ack after release unless irq still high.
REQ-033 First rising edge after reset release SHALL evaluate normally from RUN.

Verification
REQ-034 EX_MemRd=1, EX_Rt=8, ID_Rs=8 -> PC_Stall=IFID_Stall=IDEX_Flush=1 one cycle, StallCnt 0->1; EX_Rt=0 -> no stall.
REQ-035 EX_BrTaken=1 with LU and ID_Jump also 1 -> PC_Sel=10, both flushes, no stall, StallCnt unchanged.
REQ-036 irq=1 while ID_Jump=1 -> PEND held; next clean cycle TAKE: PC_Sel=11, EPC_Wr=IRQ_Ack=1 for exactly one cycle, then InKernel=1.
REQ-037 In KERN, irq=1 held 10 cycles -> no second IRQ_Ack; ID_Eret=1 -> InKernel=0 next cycle, new take follows.
REQ-038 Force StallCnt to 16'hFFFE, two LU cycles -> 16'hFFFF, stays 16'hFFFF.
REQ-039 reset low asynchronously during PEND -> all outputs zero immediately, StallCnt=0, state RUN.
